// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port seen by mem_port_arbiter.
// The arbiter uses the slave view; requesters and the memory sit on the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_dm;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_dm
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_dm
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer sharing one single-port memory between fetch (IF) and data (DM) ports.
// Define ARB_WR_POST_EN to post DM writes (ack one cycle after mem_en, no latency wait).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_dm_q, last_dm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;

  logic if_elig, dm_elig, grant_dm;

  // A port being acked this cycle has just been served; its held req is not a new request.
  assign if_elig  = bus.if_req & ~if_ack_q;
  assign dm_elig  = bus.dm_req & ~dm_ack_q;
  assign grant_dm = dm_elig & (~if_elig | ~last_dm_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dm_d  = last_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (if_elig || dm_elig) begin
          last_dm_d = grant_dm;
          we_d      = grant_dm & bus.dm_we;
          addr_d    = grant_dm ? bus.dm_addr : bus.if_addr;
          wdata_d   = grant_dm ? bus.dm_wdata : '0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        // A zero load makes WAIT capture immediately, which covers MEM_LAT == 1.
        cnt_d   = CntW'(MEM_LAT - 1);
        state_d = StWait;
`ifdef ARB_WR_POST_EN
        if (we_q) begin
          dm_ack_d = 1'b1;
          state_d  = StIdle;
        end
`endif
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          if (last_dm_q) begin
            dm_ack_d = 1'b1;
            if (!we_q) dm_rdata_d = bus.mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_dm_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dm_q  <= last_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
    end
  end

  assign bus.mem_en    = (state_q == StIssue);
  assign bus.mem_we    = (state_q == StIssue) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_dm  = bus.dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 2 and 1) driven in lockstep and checked
// against a transaction-level model of grant order, ack cycles and returned data.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req [2];
  logic        dm_req [2];
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        dm_we;

  logic        obs_if_ack [2], obs_dm_ack [2], obs_mem_en [2], obs_mem_we [2];
  logic        obs_stall_if [2], obs_stall_dm [2];
  logic [31:0] obs_if_rdata [2], obs_dm_rdata [2], obs_mem_addr [2], obs_mem_wdata [2];

  int vectors = 0;
  int errors  = 0;

  // Memory contents: a few fixed words, a hash everywhere else.
  function automatic logic [31:0] mem_val(logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h8C01_0004;
      32'h0000_0100: return 32'h1111_2222;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int Lat = (g == 0) ? 2 : 1;
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(Lat)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.if_req    = if_req[g];
    assign bus.if_addr   = if_addr;
    assign bus.dm_req    = dm_req[g];
    assign bus.dm_we     = dm_we;
    assign bus.dm_addr   = dm_addr;
    assign bus.dm_wdata  = dm_wdata;
    assign obs_if_ack[g]    = bus.if_ack;
    assign obs_dm_ack[g]    = bus.dm_ack;
    assign obs_mem_en[g]    = bus.mem_en;
    assign obs_mem_we[g]    = bus.mem_we;
    assign obs_stall_if[g]  = bus.stall_if;
    assign obs_stall_dm[g]  = bus.stall_dm;
    assign obs_if_rdata[g]  = bus.if_rdata;
    assign obs_dm_rdata[g]  = bus.dm_rdata;
    assign obs_mem_addr[g]  = bus.mem_addr;
    assign obs_mem_wdata[g] = bus.mem_wdata;

    // Memory responder: data is valid only in cycle T+Lat, garbage in every other cycle.
    int          rem = -1;
    logic [31:0] raddr = '0;
    always @(negedge clk) begin
      if (rst) rem <= -1;
      else if (bus.mem_en) begin
        rem   <= Lat;
        raddr <= bus.mem_addr;
      end else if (rem > 0) rem <= rem - 1;
      else rem <= -1;
    end
    assign bus.mem_rdata = (rem == 0) ? mem_val(raddr) : (mem_val(raddr) ^ 32'hFFFF_0000);
  end

  // Model state
  bit          last_dm [2];
  logic [31:0] m_if_rdata [2];
  logic [31:0] m_dm_rdata [2];

  task automatic chk(input string tag, input int d, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cyc%0d: observed %h expected %h", tag, d, k, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input int d, input int k, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cyc%0d: observed %b expected %b", tag, d, k, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      last_dm[d]    = 1'b0;
      m_if_rdata[d] = '0;
      m_dm_rdata[d] = '0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk1({tag, "_mem_en"}, d, 0, obs_mem_en[d], 1'b0);
      chk1({tag, "_mem_we"}, d, 0, obs_mem_we[d], 1'b0);
      chk1({tag, "_if_ack"}, d, 0, obs_if_ack[d], 1'b0);
      chk1({tag, "_dm_ack"}, d, 0, obs_dm_ack[d], 1'b0);
      chk({tag, "_mem_addr"}, d, 0, obs_mem_addr[d], 32'h0);
      chk({tag, "_mem_wdata"}, d, 0, obs_mem_wdata[d], 32'h0);
      chk({tag, "_if_rdata"}, d, 0, obs_if_rdata[d], 32'h0);
      chk({tag, "_dm_rdata"}, d, 0, obs_dm_rdata[d], 32'h0);
    end
  endtask

  // One transaction: optional IF read and/or DM access, all raised in cycle 0.
  task automatic run_txn(input bit do_if, input bit do_dm, input bit we,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
    int a_if [2], a_dm [2], i_if [2], i_dm [2];
    int last = 0;
    bit posted = 1'b0;
`ifdef ARB_WR_POST_EN
    posted = do_dm & we;
`endif
    for (int d = 0; d < 2; d++) begin
      int  dm_time = posted ? 2 : lat(d) + 2;
      int  if_time = lat(d) + 2;
      bit  dm_first = do_dm && (!do_if || !last_dm[d]);
      if (dm_first) begin
        i_dm[d] = 1;  a_dm[d] = dm_time;
        i_if[d] = a_dm[d] + 1;  a_if[d] = a_dm[d] + if_time;
      end else begin
        i_if[d] = 1;  a_if[d] = if_time;
        i_dm[d] = a_if[d] + 1;  a_dm[d] = a_if[d] + dm_time;
      end
      if (!do_if) begin i_if[d] = -1; a_if[d] = -1; end
      if (!do_dm) begin i_dm[d] = -1; a_dm[d] = -1; end
      if (a_if[d] > last) last = a_if[d];
      if (a_dm[d] > last) last = a_dm[d];
    end
    @(negedge clk);
    if_addr = ia; dm_addr = da; dm_we = we; dm_wdata = wd;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = do_if;
      dm_req[d] = do_dm;
    end
    for (int k = 0; k <= last + 2; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk1("if_ack", d, k, obs_if_ack[d], k == a_if[d]);
        chk1("dm_ack", d, k, obs_dm_ack[d], k == a_dm[d]);
        chk1("mem_en", d, k, obs_mem_en[d], (k == i_if[d]) || (k == i_dm[d]));
        if (k == i_if[d]) begin
          chk("mem_addr_if", d, k, obs_mem_addr[d], ia);
          chk1("mem_we_if", d, k, obs_mem_we[d], 1'b0);
        end
        if (k == i_dm[d]) begin
          chk("mem_addr_dm", d, k, obs_mem_addr[d], da);
          chk1("mem_we_dm", d, k, obs_mem_we[d], we);
          if (we) chk("mem_wdata", d, k, obs_mem_wdata[d], wd);
        end
        chk1("stall_if", d, k, obs_stall_if[d], do_if && k < a_if[d]);
        chk1("stall_dm", d, k, obs_stall_dm[d], do_dm && k < a_dm[d]);
        chk("if_rdata", d, k, obs_if_rdata[d],
            (do_if && k >= a_if[d]) ? mem_val(ia) : m_if_rdata[d]);
        chk("dm_rdata", d, k, obs_dm_rdata[d],
            (do_dm && !we && k >= a_dm[d]) ? mem_val(da) : m_dm_rdata[d]);
        if (obs_if_ack[d]) if_req[d] = 1'b0;
        if (obs_dm_ack[d]) dm_req[d] = 1'b0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 1'b0;
      dm_req[d] = 1'b0;
      if (do_if) m_if_rdata[d] = mem_val(ia);
      if (do_dm && !we) m_dm_rdata[d] = mem_val(da);
      if (do_if && do_dm) last_dm[d] = (a_dm[d] > a_if[d]);
      else if (do_if || do_dm) last_dm[d] = do_dm;
    end
  endtask

  // Both ports keep requesting, each re-raising req the cycle after its ack; six grants.
  task automatic contend(input logic [31:0] ia, input logic [31:0] da);
    int n [2], when [2][6], who [2][6];
    bit rr_if [2], rr_dm [2];
    for (int d = 0; d < 2; d++) begin
      n[d] = 0; rr_if[d] = 1'b0; rr_dm[d] = 1'b0;
      for (int j = 0; j < 6; j++) begin when[d][j] = -1; who[d][j] = -1; end
    end
    @(negedge clk);
    if_addr = ia; dm_addr = da; dm_we = 1'b0; dm_wdata = '0;
    for (int d = 0; d < 2; d++) begin if_req[d] = 1'b1; dm_req[d] = 1'b1; end
    for (int k = 0; k < 80; k++) begin
      if (k > 0) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rr_if[d]) begin if_req[d] = 1'b1; rr_if[d] = 1'b0; end
        if (rr_dm[d]) begin dm_req[d] = 1'b1; rr_dm[d] = 1'b0; end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        if (obs_dm_ack[d] && n[d] < 6) begin
          who[d][n[d]] = 1; when[d][n[d]] = k; n[d]++;
          dm_req[d] = 1'b0; rr_dm[d] = (n[d] < 5);
        end
        if (obs_if_ack[d] && n[d] < 6) begin
          who[d][n[d]] = 0; when[d][n[d]] = k; n[d]++;
          if_req[d] = 1'b0; rr_if[d] = (n[d] < 5);
        end
      end
      if (n[0] == 6 && n[1] == 6) break;
    end
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 6; j++) begin
        int exp_dm = (!last_dm[d]) ^ (j % 2);
        chk("grant_order", d, j, who[d][j], exp_dm);
        chk("grant_cycle", d, j, when[d][j], (j + 1) * (lat(d) + 2));
      end
      if_req[d] = 1'b0; dm_req[d] = 1'b0;
      last_dm[d] = last_dm[d];  // even number of grants ends on the port that lost the first tie
      m_if_rdata[d] = mem_val(ia);
      m_dm_rdata[d] = mem_val(da);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_we = 1'b0;
    for (int d = 0; d < 2; d++) begin if_req[d] = 1'b0; dm_req[d] = 1'b0; end
    reset_model();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(posedge clk); #2 rst = 1'b0;

    // Contention straight after reset: DM wins the first tie.
    run_txn(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0100, 32'h0);
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0);
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0200, 32'hDEAD_BEEF);
    run_txn(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0300, 32'hCAFE_F00D);
    contend(32'h0000_0080, 32'h0000_0100);

    for (int t = 0; t < 40; t++) begin
      int sel = $urandom_range(0, 2);
      run_txn(sel != 1, sel != 0, 1'($urandom_range(0, 1)),
              $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom);
    end

    // Reset in the middle of a DM read: access abandoned, no ack, fresh timing afterwards.
    @(negedge clk);
    dm_addr = 32'h0000_0100; dm_we = 1'b0;
    for (int d = 0; d < 2; d++) dm_req[d] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) dm_req[d] = 1'b0;
    #1 check_reset_outputs("midrst");
    reset_model();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk1("rst_dm_ack", d, k, obs_dm_ack[d], 1'b0);
        chk1("rst_mem_en", d, k, obs_mem_en[d], 1'b0);
      end
    end
    @(posedge clk); #2 rst = 1'b0;
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 32'h0);
    run_txn(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0444, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbiter and sequencer that shares one single-port instruction/data memory between the fetch stage (read-only port "if") and the memory stage (read/write port "dm") of the pipelined CPU. It accepts level-held requests from each stage, issues one memory access at a time, and waits a fixed memory latency. It returns read data with a one-cycle ack and drives per-port stall signals into the hazard manager.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LAT, 2, cycles from the mem_en cycle to the cycle where mem_rdata is valid; legal values are 1 and above

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request; held high until if_ack
if_addr  in  ADDR_W  fetch address; stable while if_req is high
if_rdata  out  DATA_W  fetched word; valid in the if_ack cycle, held afterwards
if_ack  out  1  one-cycle completion pulse for the fetch port
dm_req  in  1  data request; held high until dm_ack
dm_we  in  1  1 = write, 0 = read; stable while dm_req is high
dm_addr  in  ADDR_W  data address; stable while dm_req is high
dm_wdata  in  DATA_W  write data; stable while dm_req is high
dm_rdata  out  DATA_W  load result; valid in the dm_ack cycle, held afterwards
dm_ack  out  1  one-cycle completion pulse for the data port
mem_en  out  1  memory access strobe, exactly one cycle per access
mem_we  out  1  memory write enable; qualified by mem_en
mem_addr  out  ADDR_W  memory address; registered
mem_wdata  out  DATA_W  memory write data; registered
mem_rdata  in  DATA_W  memory read data
stall_if  out  1  combinational: if_req & ~if_ack
stall_dm  out  1  combinational: dm_req & ~dm_ack

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE; the latency counter is cleared.
  - mem_en, mem_we, if_ack and dm_ack go to 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata go to 0.
  - last_grant is set to IF, so DM wins the first tie.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - Samples the eligible requests. A port whose ack is high in the current cycle is not eligible.
  - If exactly one port is eligible, it is granted.
  - If both are eligible, the port that is not last_grant is granted (round-robin).
  - On a grant: register the port's address, write data and we into mem_*, record the grant in last_grant, and move to ISSUE.
- ISSUE (cycle T):
  - mem_en is 1 and mem_we is 1 only for a DM write.
  - The counter loads MEM_LAT-1. Next state is WAIT, or straight to capture when MEM_LAT is 1.
- WAIT:
  - The counter decrements every cycle.
  - In cycle T+MEM_LAT, mem_rdata is captured into the granted port's rdata register.
  - Next state is IDLE.
- Ack timing:
  - The granted port's ack is high for exactly one cycle, T+MEM_LAT+1, which is also the first IDLE cycle.
  - A new grant can be decided in that same cycle, so there is no bubble beyond the ack.
- Single access latency: request sampled in cycle 0, mem_en in cycle 1, ack in cycle MEM_LAT+2.
- DM writes:
  - Follow the same timing as reads.
  - dm_rdata is not updated and keeps its previous value.
- Only one access is outstanding at any time. A request that arrives while ISSUE or WAIT is active waits, with its stall held high.
- Fairness: under continuous contention, grants alternate DM, IF, DM, IF. No port waits for more than one foreign access.
- Reset mid-access: the in-flight access is abandoned and no ack is generated. Requesters re-arbitrate after rst is released.
- Requests are not cancellable. Deasserting req before ack is a protocol violation and its behaviour is undefined.

Optional Feature:
Macro ARB_WR_POST_EN.
- Defined:
  - DM writes are posted: dm_ack is high in cycle T+1 and the FSM returns to IDLE from ISSUE without the WAIT latency.
  - Reads are unchanged.
- Undefined: writes take the full MEM_LAT latency, as described in Behaviour.

Test Plan:
1. IF read only, MEM_LAT=2: if_addr=0x00000040, memory returns 0x8C010004 -> mem_en=1 in cycle 1 with mem_addr=0x40; if_ack in cycle 4 with if_rdata=0x8C010004; stall_if high in cycles 0-3.
2. Both ports request in cycle 0 after reset: dm read at 0x100 returning 0x11112222, if read at 0x0 -> DM granted first with dm_ack in cycle 4; IF mem_en in cycle 5; if_ack in cycle 8.
3. DM write of 0xDEADBEEF to 0x200 -> mem_en=1, mem_we=1 and mem_wdata=0xDEADBEEF in cycle 1; dm_ack in cycle 4 without the macro and cycle 2 with ARB_WR_POST_EN; dm_rdata is unchanged.
4. Continuous if_req and dm_req for 4 accesses, each port re-requesting the cycle after its ack -> grant order DM, IF, DM, IF; no two consecutive grants go to the same port.
5. rst asserted in cycle 2 of a DM read -> all outputs go to 0 immediately and no dm_ack is produced; after release a re-issued request completes with fresh timing (ack at release+4).
6. MEM_LAT=1: a single IF read -> mem_en in cycle 1, if_ack in cycle 3, with data captured in cycle 2.
